// File: rtl/phase_dec_pkg.sv
// Shared types and vote encoding for the CDR phase decoder.
// Vote decode turns the encoder compare pair into a signed step.
package phase_dec_pkg;

  typedef enum logic {
    ACQ    = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam int VOTE_UP   = 1;
  localparam int VOTE_DN   = -1;
  localparam int VOTE_HOLD = 0;

  // equal dominates: the encoder leaves comp stale while equal is set
  function automatic int vote_of(
    input logic equal,
    input logic comp
  );
    int v;
    v = VOTE_HOLD;
    unique case (1'b1)
      equal:           v = VOTE_HOLD;
      (!equal && comp):  v = VOTE_UP;
      (!equal && !comp): v = VOTE_DN;
      default:         v = VOTE_HOLD;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/phase_decoder_vote.sv
// Signed vote integrator: strobes a step when the running sum
// hits +/-THRESH and clears itself on that edge.
module vote_filter
  import phase_dec_pkg::*;
#(
  parameter int CNT_W  = 4,
  parameter int THRESH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic signed [CNT_W-1:0] i_d,
  output logic                    o_step_up,
  output logic                    o_step_dn
);

  localparam logic signed [CNT_W-1:0] TH_P = CNT_W'(THRESH);
  localparam logic signed [CNT_W-1:0] TH_N = -TH_P;

  logic signed [CNT_W-1:0] r_vote;
  logic signed [CNT_W-1:0] w_next;

  always_comb begin
    w_next    = r_vote + i_d;
    o_step_up = i_en && (w_next == TH_P);
    o_step_dn = i_en && (w_next == TH_N);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_vote <= '0;
    end else if (i_en) begin
      if (o_step_up || o_step_dn) r_vote <= '0;
      else                        r_vote <= w_next;
    end
  end

endmodule

// File: rtl/phase_decoder.sv
// CDR phase decoder: vote filter, PI phase select with wrap,
// equal-run lock detector and step pulses.
module phase_decoder
  import phase_dec_pkg::*;
#(
  parameter int NUM_PH   = 16,
  parameter int PH_W     = 4,
  parameter int THRESH   = 4,
  parameter int CNT_W    = 4,
  parameter int LOCK_CNT = 8,
  parameter int LOCK_W   = 4
) (
  input  logic            clk_cont,
  input  logic            rst,
  input  logic            en,
  input  logic            comp,
  input  logic            equal,
  output logic [PH_W-1:0] phase_sel,
  output logic            ph_up,
  output logic            ph_dn,
  output logic            locked
);

  localparam logic [PH_W-1:0]   PH_MAX   = PH_W'(NUM_PH - 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

  logic signed [CNT_W-1:0] w_d;
  logic                    w_step_up;
  logic                    w_step_dn;
  logic [PH_W-1:0]         w_ph_inc;
  logic [PH_W-1:0]         w_ph_dec;
  logic [LOCK_W-1:0]       w_run_next;
  state_t                  w_state_next;

  logic [PH_W-1:0]   r_phase;
  logic              r_ph_up;
  logic              r_ph_dn;
  logic [LOCK_W-1:0] r_run;
  state_t            r_state;

  always_comb begin
    w_d = CNT_W'(vote_of(equal, comp));
  end

  vote_filter #(
    .CNT_W (CNT_W),
    .THRESH(THRESH)
  ) u_vf (
    .i_clk    (clk_cont),
    .i_rst    (rst),
    .i_en     (en),
    .i_d      (w_d),
    .o_step_up(w_step_up),
    .o_step_dn(w_step_dn)
  );

  always_comb begin
    w_ph_inc = (r_phase == PH_MAX) ? '0 : r_phase + PH_W'(1);
    w_ph_dec = (r_phase == '0) ? PH_MAX : r_phase - PH_W'(1);
    w_run_next = '0;
    if (equal) begin
      w_run_next = (r_run == LOCK_MAX) ? r_run : r_run + LOCK_W'(1);
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (en) begin
      unique case (r_state)
        ACQ:    if (equal && w_run_next == LOCK_MAX) w_state_next = LOCKED;
        LOCKED: if (w_step_up || w_step_dn) w_state_next = ACQ;
        default: w_state_next = ACQ;
      endcase
    end
  end

  always_ff @(posedge clk_cont) begin
    if (rst) begin
      r_state <= ACQ;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk_cont) begin
    if (rst) begin
      r_phase <= '0;
      r_ph_up <= 1'b0;
      r_ph_dn <= 1'b0;
      r_run   <= '0;
    end else begin
      r_ph_up <= w_step_up;
      r_ph_dn <= w_step_dn;
      if (en) begin
        r_run <= w_run_next;
        if (w_step_up)      r_phase <= w_ph_inc;
        else if (w_step_dn) r_phase <= w_ph_dec;
      end
    end
  end

  assign phase_sel = r_phase;
  assign ph_up     = r_ph_up;
  assign ph_dn     = r_ph_dn;
  assign locked    = (r_state == LOCKED);

endmodule

// File: tb/tb_phase_decoder.sv
// Scoreboard bench for phase_decoder: expected step events are
// queued by the stimulus and popped by a pulse monitor.
module tb_phase_decoder;

  typedef struct {
    logic       up;
    logic [3:0] ph;
    logic       lk;
  } ev_t;

  logic clk;
  logic rst, en, en12, comp, equal;
  logic [3:0] phase_sel, phase12;
  logic ph_up, ph_dn, locked;
  logic ph_up12, ph_dn12, locked12;

  ev_t q[$];
  ev_t e;
  int total = 0;
  int bad = 0;

  phase_decoder #(
    .NUM_PH(16), .PH_W(4), .THRESH(4),
    .CNT_W(4), .LOCK_CNT(8), .LOCK_W(4)
  ) u_dut (
    .clk_cont (clk),
    .rst      (rst),
    .en       (en),
    .comp     (comp),
    .equal    (equal),
    .phase_sel(phase_sel),
    .ph_up    (ph_up),
    .ph_dn    (ph_dn),
    .locked   (locked)
  );

  phase_decoder #(
    .NUM_PH(12), .PH_W(4), .THRESH(4),
    .CNT_W(4), .LOCK_CNT(8), .LOCK_W(4)
  ) u_dut12 (
    .clk_cont (clk),
    .rst      (rst),
    .en       (en12),
    .comp     (comp),
    .equal    (equal),
    .phase_sel(phase12),
    .ph_up    (ph_up12),
    .ph_dn    (ph_dn12),
    .locked   (locked12)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor: every step pulse must match the next queued event
  always @(posedge clk) begin
    #1;
    if (ph_up || ph_dn) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse up=%0b dn=%0b ph=%0d want=no_pulse",
                 ph_up, ph_dn, phase_sel);
      end else begin
        e = q.pop_front();
        if (ph_up !== e.up || ph_dn !== !e.up ||
            phase_sel !== e.ph || locked !== e.lk) begin
          bad++;
          $display("FAIL step_event got up=%0b dn=%0b ph=%0d lk=%0b want up=%0b dn=%0b ph=%0d lk=%0b",
                   ph_up, ph_dn, phase_sel, locked, e.up, !e.up, e.ph, e.lk);
        end
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", n, act, exp);
    end
  endtask

  task automatic cyc(input logic ie, input logic ic, input logic iq);
    @(negedge clk);
    en = ie;
    comp = ic;
    equal = iq;
  endtask

  task automatic cyc12(input logic ic, input logic iq);
    @(negedge clk);
    en = 1'b0;
    en12 = 1'b1;
    comp = ic;
    equal = iq;
  endtask

  task automatic idle();
    @(negedge clk);
    en = 1'b0;
    en12 = 1'b0;
    comp = 1'b0;
    equal = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    en12 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic push(input logic up, input logic [3:0] ph,
                      input logic lk);
    ev_t ev;
    ev.up = up;
    ev.ph = ph;
    ev.lk = lk;
    q.push_back(ev);
  endtask

  task automatic drain(input string n);
    idle();
    idle();
    chk(n, q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; en12 = 1'b0;
    comp = 1'b0; equal = 1'b0;

    // reset state
    do_reset();
    chk("rst_phase", phase_sel, 0);
    chk("rst_up", ph_up, 0);
    chk("rst_dn", ph_dn, 0);
    chk("rst_locked", locked, 0);
    chk("rst_vote", u_dut.u_vf.r_vote, 0);

    // 1: four up votes -> one up step
    push(1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    idle();
    chk("t1_phase", phase_sel, 1);
    chk("t1_vote", u_dut.u_vf.r_vote, 0);
    drain("t1_drain");

    // 2: down wrap 0->15, then 16 up steps wrapping 15->0
    do_reset();
    push(1'b0, 4'd15, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0);
    idle();
    chk("t2_dn_wrap", phase_sel, 15);
    for (int k = 1; k <= 16; k++) begin
      push(1'b1, 4'((15 + k) % 16), 1'b0);
      for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    end
    idle();
    chk("t2_up_wrap", phase_sel, 15);
    drain("t2_drain");

    // 3: lock after 8 equals, then an up step drops lock
    do_reset();
    for (int i = 0; i < 7; i++) cyc(1, i[0], 1);
    idle();
    chk("t3_not_yet", locked, 0);
    cyc(1, 1, 1);
    idle();
    chk("t3_locked", locked, 1);
    push(1'b1, 4'd1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    idle();
    chk("t3_unlock", locked, 0);
    drain("t3_drain");

    // 4: alternating votes while locked -> no steps, lock held
    do_reset();
    for (int i = 0; i < 8; i++) cyc(1, 0, 1);
    idle();
    chk("t4_locked", locked, 1);
    for (int i = 0; i < 100; i++) cyc(1, ~i[0], 0);
    idle();
    chk("t4_still_locked", locked, 1);
    chk("t4_vote", u_dut.u_vf.r_vote, 0);
    chk("t4_phase", phase_sel, 0);
    drain("t4_drain");

    // 5: freeze with en=0 keeps the partial vote
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 1, 0);
    chk("t5_vote_held", u_dut.u_vf.r_vote, 3);
    chk("t5_phase_held", phase_sel, 0);
    push(1'b1, 4'd1, 1'b0);
    cyc(1, 1, 0);
    idle();
    chk("t5_phase", phase_sel, 1);
    chk("t5_pulse", ph_up, 1);
    drain("t5_drain");

    // 6: reset on the threshold edge wins
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1, 1, 0);
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    comp = 1'b1;
    equal = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    en = 1'b0;
    chk("t6_phase", phase_sel, 0);
    chk("t6_up", ph_up, 0);
    chk("t6_vote", u_dut.u_vf.r_vote, 0);
    drain("t6_drain");

    // 6b: NUM_PH=12 wraps 0->11 and back
    do_reset();
    for (int i = 0; i < 4; i++) cyc12(0, 0);
    idle();
    chk("t6b_dn_pulse", ph_dn12, 1);
    chk("t6b_wrap11", phase12, 11);
    for (int i = 0; i < 4; i++) cyc12(1, 0);
    idle();
    chk("t6b_up_pulse", ph_up12, 1);
    chk("t6b_wrap0", phase12, 0);
    drain("t6b_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
